uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 165 ++++++++++++++++
 tb/tb_uart_receiver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with programmable oversampling, mid-bit sampling,
// frame/break detection and a one-deep holding register with overrun flag.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] baud_div,
    input  logic        rx,
    input  logic        rd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [15:0] HALF = 16'(OVERSAMPLE / 2);
    localparam logic [15:0] FULL = 16'(OVERSAMPLE);

    logic        rx_s1_q, rx_s2_q;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  state_q, state_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [2:0]  bidx_q, bidx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    logic        rx_s;
    logic        tick;
    logic        done;
    logic [31:0] div_eff;
    logic [15:0] tcnt_inc;

    assign rx_s     = rx_s2_q;
    assign div_eff  = (baud_div == 32'd0) ? 32'd1 : baud_div;
    assign tick     = (cnt_q == 32'd1);
    assign tcnt_inc = tcnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        done    = 1'b0;
        cnt_d   = (cnt_q <= 32'd1) ? div_eff : cnt_q - 32'd1;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    tcnt_d  = 16'd0;
                    cnt_d   = div_eff;
                end
            end
            S_START: begin
                if (tick) begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc == HALF) begin
                        tcnt_d  = 16'd0;
                        bidx_d  = 3'd0;
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc == FULL) begin
                        tcnt_d  = 16'd0;
                        shift_d = {rx_s, shift_q[7:1]};
                        bidx_d  = bidx_q + 3'd1;
                        if (bidx_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc == FULL) begin
                        tcnt_d  = 16'd0;
                        done    = 1'b1;
                        state_d = rx_s ? S_IDLE : S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Disabling abandons any partial byte; the holding register is untouched.
        if (!enable) begin
            state_d = S_IDLE;
            tcnt_d  = 16'd0;
            cnt_d   = div_eff;
            done    = 1'b0;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ferr_d  = ~rx_s;
            ovr_d   = rd ? 1'b0 : (ovr_q | valid_q);
        end else if (rd && valid_q) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            cnt_q   <= 32'd0;
            state_q <= S_IDLE;
            tcnt_q  <= 16'd0;
            bidx_q  <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frames are scheduled into a queue of expected
// completions and the holding-register outputs are compared every cycle.
module tb_uart_receiver;

    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] baud_div = 32'd4;
    logic        rx = 1'b1;
    logic        rd = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .baud_div (baud_div),
        .rx       (rx),
        .rd       (rd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] d;
        logic       fe;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         rise_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00;

    // Reference: a byte lands at its scheduled edge; rd clears only otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_valid <= 1'b0;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
            m_data  <= 8'h00;
            q.delete();
        end else begin
            if (!enable) q.delete();
            if (q.size() > 0 && q[0].at == cyc + 1) begin
                m_ovr   <= rd ? 1'b0 : (m_ovr | m_valid);
                m_valid <= 1'b1;
                m_data  <= q[0].d;
                m_ferr  <= q[0].fe;
                void'(q.pop_front());
            end else if (rd && m_valid) begin
                m_valid <= 1'b0;
                m_ferr  <= 1'b0;
                m_ovr   <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ({rx_valid, rx_data, frame_err, overrun} !==
                {m_valid, m_data, m_ferr, m_ovr}) begin
                bad++;
                if (bad < 20)
                    $display("FAIL cycle %0d: dut v=%b d=%h fe=%b ov=%b, model v=%b d=%h fe=%b ov=%b",
                             cyc, rx_valid, rx_data, frame_err, overrun,
                             m_valid, m_data, m_ferr, m_ovr);
            end
        end
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
        prev_valid <= rx_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic line_high(input int n, input bit rnd_rd);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
            rd = rnd_rd ? ($urandom_range(0, 15) == 0) : 1'b0;
        end
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // mode: 0 no rd, 1 random rd, 2 rd on the completion edge; len<0 = full frame
    task automatic send(input logic [7:0] d, input logic stopb, input int mode,
                        input int len, output int start);
        int         de;
        int         bt;
        int         n;
        int         done_at;
        logic [9:0] fr;
        de      = (baud_div == 0) ? 1 : int'(baud_div);
        bt      = OS * de;
        n       = (len < 0) ? 10 * bt : len;
        fr      = {stopb, d, 1'b0};
        start   = 0;
        done_at = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start   = cyc;
                done_at = cyc + 3 + (OS / 2 + 9 * OS) * de;
                q.push_back('{done_at, d, ~stopb});
            end
            rx = fr[k / bt];
            case (mode)
                1:       rd = ($urandom_range(0, 63) == 0);
                2:       rd = (cyc == done_at - 1);
                default: rd = 1'b0;
            endcase
        end
    endtask

    initial begin
        int s0;
        int dummy;
        @(negedge clk);
        chk("reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_data", {24'd0, rx_data}, 32'h00);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        line_high(4, 1'b0);
        chk("idle_flags", {29'd0, rx_valid, frame_err, overrun}, 32'd0);

        baud_div = 32'd4;
        send(8'hA5, 1'b1, 0, -1, s0);
        line_high(4, 1'b0);
        chk("a5_data", {24'd0, rx_data}, 32'hA5);
        chk("a5_valid", {31'd0, rx_valid}, 32'd1);
        chk("a5_ferr", {31'd0, frame_err}, 32'd0);
        chk("a5_latency", rise_cyc - s0, 32'd611);

        pulse_rd();
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        line_high(100, 1'b0);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        chk("glitch_flags", {30'd0, rx_valid, frame_err}, 32'd0);

        send(8'h3C, 1'b0, 0, -1, dummy);
        repeat (200) @(negedge clk);
        chk("brk_busy", {31'd0, busy}, 32'd1);
        chk("brk_data", {24'd0, rx_data}, 32'h3C);
        chk("brk_ferr", {31'd0, frame_err}, 32'd1);
        line_high(5, 1'b0);
        chk("brk_exit", {31'd0, busy}, 32'd0);
        send(8'h55, 1'b1, 0, -1, dummy);
        line_high(6, 1'b0);
        chk("post_brk_data", {24'd0, rx_data}, 32'h55);
        chk("post_brk_ferr", {31'd0, frame_err}, 32'd0);

        send(8'h11, 1'b1, 0, -1, dummy);
        line_high(6, 1'b0);
        send(8'h22, 1'b1, 0, -1, dummy);
        line_high(6, 1'b0);
        chk("ovr_data", {24'd0, rx_data}, 32'h22);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        pulse_rd();
        chk("ovr_rd", {30'd0, rx_valid, overrun}, 32'd0);

        send(8'h66, 1'b1, 0, -1, dummy);
        line_high(6, 1'b0);
        send(8'h77, 1'b1, 2, -1, dummy);
        line_high(6, 1'b0);
        chk("rdwin_data", {24'd0, rx_data}, 32'h77);
        chk("rdwin_flags", {30'd0, rx_valid, overrun}, 32'd2);

        send(8'h00, 1'b1, 0, 5 * 64 + 32, dummy);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        line_high(128, 1'b0);
        chk("rst_abandon", {31'd0, rx_valid}, 32'd0);
        send(8'h0F, 1'b1, 0, -1, dummy);
        line_high(6, 1'b0);
        chk("rst_0f", {23'd0, rx_valid, rx_data}, 32'h10F);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);

        pulse_rd();
        send(8'h00, 1'b1, 0, 5 * 64 + 32, dummy);
        enable = 1'b0;
        rx     = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        line_high(128, 1'b0);
        chk("en_abandon", {31'd0, rx_valid}, 32'd0);
        send(8'h0F, 1'b1, 0, -1, dummy);
        line_high(6, 1'b0);
        chk("en_0f", {23'd0, rx_valid, rx_data}, 32'h10F);
        chk("en_ferr", {31'd0, frame_err}, 32'd0);

        for (int i = 0; i < 80; i++) begin
            baud_div = 32'($urandom_range(0, 2));
            send(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 3) == 0) ? 2 : 1, -1, dummy);
            line_high($urandom_range(6, 30), 1'b1);
        end
        line_high(10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
